// File: rtl/parameter_pkg.sv
// Shared encodings for the sized data memory: access-size codes and size/offset helpers.
package parameter_pkg;

   typedef logic [1:0] mem_size_t;

   localparam mem_size_t MEM_SIZE_B   = 2'b00;
   localparam mem_size_t MEM_SIZE_H   = 2'b01;
   localparam mem_size_t MEM_SIZE_W   = 2'b10;
   localparam mem_size_t MEM_SIZE_ILL = 2'b11;

   // Byte lanes touched within the aligned 32-bit word.
   function automatic logic [3:0] size_byte_en(mem_size_t size, logic [1:0] off);
      case (size)
         MEM_SIZE_B: return 4'b0001 << off;
         MEM_SIZE_H: return 4'b0011 << off;
         MEM_SIZE_W: return 4'b1111;
         default:    return 4'b0000;
      endcase
   endfunction

   function automatic logic size_misaligned(mem_size_t size, logic [1:0] off);
      case (size)
         MEM_SIZE_H: return off[0];
         MEM_SIZE_W: return off != 2'b00;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_sized_if.sv
// Request/response bus between a load/store unit (master) and the sized data memory (slave).
interface data_mem_sized_if
   import parameter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 6
);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   mem_size_t             req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [TAG_WIDTH-1:0]  req_tag;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic [TAG_WIDTH-1:0]  resp_tag;
   logic                  resp_fault;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_tag, resp_fault
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_tag, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_tag, resp_fault
   );

endinterface

// File: rtl/data_mem_sized_load_extend.sv
// Selects the addressed byte/half/word from a stored 32-bit word and sign- or zero-extends it.
module load_extend
   import parameter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  mem_size_t             size_i,
   input  logic                  unsigned_i,
   input  logic [1:0]            offset_i,
   input  logic [DATA_WIDTH-1:0] word_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      shifted = word_i >> {offset_i, 3'b000};
      case (size_i)
         MEM_SIZE_B: data_o = unsigned_i ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                         : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         MEM_SIZE_H: data_o = unsigned_i ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                         : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
         default:    data_o = word_i;
      endcase
   end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed data memory with sized loads/stores, fault detection and an in-order,
// stall-able response pipeline of READ_LATENCY stages.
module data_mem_sized
   import parameter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned MEM_BYTES    = 4096,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned TAG_WIDTH    = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [MEM_BYTES*8-1:0] init_data,
   data_mem_sized_if.slave        bus
);

   localparam int unsigned IdxW = $clog2(MEM_BYTES);

   typedef struct packed {
      logic                  valid;
      logic                  we;
      mem_size_t             size;
      logic                  uns;
      logic [1:0]            off;
      logic                  fault;
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } stage_t;

   logic [7:0]            mem_q [MEM_BYTES];
   stage_t                stage_q [READ_LATENCY];
   stage_t                stage_d;
   stage_t                out_s;

   logic [ADDR_WIDTH-1:0] addr;
   logic [IdxW-1:0]       base;
   logic [3:0]            byte_en;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] wr_lane;
   logic [DATA_WIDTH-1:0] ext_data;
   logic                  advance;
   logic                  accept;
   logic                  fault;

   assign addr    = bus.req_addr;
   assign out_s   = stage_q[READ_LATENCY-1];
   // The whole pipeline moves only when the output stage is empty or being consumed.
   assign advance = !(out_s.valid && !bus.resp_ready);
   assign accept  = bus.req_valid && bus.req_ready;
   assign base    = {addr[IdxW-1:2], 2'b00};
   assign byte_en = size_byte_en(bus.req_size, addr[1:0]);
   assign wr_lane = bus.req_wdata << {addr[1:0], 3'b000};
   assign fault   = (bus.req_size == MEM_SIZE_ILL) || size_misaligned(bus.req_size, addr[1:0]) ||
                    ((addr >> IdxW) != '0);

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < 4; k++) begin
         rd_word[8*k +: 8] = mem_q[base | IdxW'(k)];
      end
   end

   always_comb begin
      stage_d = '0;
      if (accept) begin
         stage_d.valid = 1'b1;
         stage_d.we    = bus.req_we;
         stage_d.size  = bus.req_size;
         stage_d.uns   = bus.req_unsigned;
         stage_d.off   = addr[1:0];
         stage_d.fault = fault;
         stage_d.tag   = bus.req_tag;
         stage_d.data  = (bus.req_we || fault) ? '0 : rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_BYTES; i++) begin
            mem_q[i] <= init_data[i*8 +: 8];
         end
         for (int i = 0; i < READ_LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else if (advance) begin
         stage_q[0] <= stage_d;
         for (int i = 1; i < READ_LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
         if (accept && bus.req_we && !fault) begin
            for (int k = 0; k < 4; k++) begin
               if (byte_en[k]) begin
                  mem_q[base | IdxW'(k)] <= wr_lane[8*k +: 8];
               end
            end
         end
      end
   end

   load_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_extend (
      .size_i     (out_s.size),
      .unsigned_i (out_s.uns),
      .offset_i   (out_s.off),
      .word_i     (out_s.data),
      .data_o     (ext_data)
   );

   assign bus.req_ready  = advance && !rst;
   assign bus.resp_valid = out_s.valid;
   assign bus.resp_tag   = out_s.tag;
   assign bus.resp_fault = out_s.fault;
   assign bus.resp_rdata = (out_s.valid && !out_s.we && !out_s.fault) ? ext_data : '0;

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: directed vector table, corner-case sequences and random traffic
// checked cycle by cycle against a queue-based reference model.
module tb_data_mem_sized;
   import parameter_pkg::*;

   localparam int unsigned MB = 4096;
   localparam int unsigned RL = 2;
   localparam int unsigned TW = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic [MB*8-1:0]  init_data;

   always #5 clk = ~clk;

   data_mem_sized_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(TW)) bus ();

   data_mem_sized #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (32),
      .MEM_BYTES    (MB),
      .READ_LATENCY (RL),
      .TAG_WIDTH    (TW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init_data (init_data),
      .bus       (bus)
   );

   typedef struct {
      logic [31:0]   rdata;
      logic          fault;
      logic [TW-1:0] tag;
      int            age;
   } resp_t;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      string       name;
   } vec_t;

   resp_t      pend[$];
   resp_t      got[$];
   vec_t       vecs[$];
   logic [7:0] init_b [MB];
   logic [7:0] mdl [MB];
   int         n_cmp = 0;
   int         n_err = 0;
   bit         chk_en = 0;
   bit         last_acc;
   bit         saw_ready_low;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Spec-level model of one accepted request: updates model memory, returns the response.
   task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [TW-1:0] tag, output resp_t r);
      int          n;
      logic [31:0] v;
      bit          f;
      n = 1 << size;
      f = (size == 2'b11) || ((a % n) != 0) || (a >= MB);
      r.tag = tag;
      r.fault = f;
      r.rdata = '0;
      r.age = 1;
      if (!f) begin
         if (we) begin
            for (int k = 0; k < n; k++) mdl[a+k] = wd[8*k +: 8];
         end else begin
            v = '0;
            for (int k = 0; k < n; k++) v |= 32'(mdl[a+k]) << (8*k);
            if (!uns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
            r.rdata = v;
         end
      end
   endtask

   task automatic step();
      bit    vis;
      bit    rdy;
      resp_t r;
      @(negedge clk);
      vis = (pend.size() > 0) && (pend[0].age == RL);
      rdy = !rst && !(vis && !bus.resp_ready);
      if (chk_en) begin
         chk("req_ready", 32'(bus.req_ready), 32'(rdy));
         chk("resp_valid", 32'(bus.resp_valid), 32'(vis));
         if (vis) begin
            chk("resp_rdata", bus.resp_rdata, pend[0].rdata);
            chk("resp_fault", 32'(bus.resp_fault), 32'(pend[0].fault));
            chk("resp_tag", 32'(bus.resp_tag), 32'(pend[0].tag));
         end
      end
      if (!rst && !bus.req_ready) saw_ready_low = 1;
      if (bus.resp_valid && bus.resp_ready && !rst)
         got.push_back('{bus.resp_rdata, bus.resp_fault, bus.resp_tag, 0});
      last_acc = rdy && bus.req_valid;
      @(posedge clk);
      if (rst) begin
         pend.delete();
         foreach (mdl[i]) mdl[i] = init_b[i];
      end else if (rdy) begin
         if (vis) void'(pend.pop_front());
         foreach (pend[i]) pend[i].age++;
         if (bus.req_valid) begin
            model_req(bus.req_we, bus.req_size, bus.req_unsigned, bus.req_addr, bus.req_wdata,
                      bus.req_tag, r);
            pend.push_back(r);
         end
      end
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [TW-1:0] tag);
      bus.req_valid = 1'b1;
      bus.req_we = we;
      bus.req_size = sz;
      bus.req_unsigned = uns;
      bus.req_addr = a;
      bus.req_wdata = wd;
      bus.req_tag = tag;
      for (int i = 0; i < 20; i++) begin
         step();
         if (last_acc) break;
      end
      chk("issue_accepted", 32'(last_acc), 32'd1);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_resp(input int n);
      for (int i = 0; i < 40; i++) begin
         if (got.size() >= n) break;
         step();
      end
      chk("resp_arrived", 32'(got.size() >= n), 32'd1);
   endtask

   function automatic logic [31:0] init_word(input int a);
      return {init_b[a+3], init_b[a+2], init_b[a+1], init_b[a]};
   endfunction

   initial begin
      int nt;
      for (int i = 0; i < MB; i++) init_b[i] = 8'($urandom);
      init_b[16'h10] = 8'h78;
      init_b[16'h11] = 8'h56;
      init_b[16'h12] = 8'h34;
      init_b[16'h13] = 8'h12;
      for (int i = 0; i < MB; i++) init_data[i*8 +: 8] = init_b[i];

      rst = 1'b1;
      bus.req_valid = 0; bus.req_we = 0; bus.req_size = MEM_SIZE_W; bus.req_unsigned = 0;
      bus.req_addr = '0; bus.req_wdata = '0; bus.req_tag = '0; bus.resp_ready = 1'b1;
      step();
      chk_en = 1;
      step();
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
      chk("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      step();

      vecs.push_back('{0, MEM_SIZE_W, 0, 32'h10, 32'h0, 32'h12345678, 0, "lw_10"});
      vecs.push_back('{1, MEM_SIZE_B, 0, 32'h11, 32'h80, 32'h0, 0, "sb_11"});
      vecs.push_back('{0, MEM_SIZE_B, 0, 32'h11, 32'h0, 32'hFFFFFF80, 0, "lb_11"});
      vecs.push_back('{0, MEM_SIZE_B, 1, 32'h11, 32'h0, 32'h00000080, 0, "lbu_11"});
      vecs.push_back('{0, MEM_SIZE_W, 0, 32'h10, 32'h0, 32'h12348078, 0, "lw_10_after"});
      vecs.push_back('{0, MEM_SIZE_H, 0, 32'h12, 32'h0, 32'h00001234, 0, "lh_12"});
      vecs.push_back('{0, MEM_SIZE_H, 0, 32'h13, 32'h0, 32'h0, 1, "lh_13_mis"});
      vecs.push_back('{1, MEM_SIZE_W, 0, 32'h1002, 32'hDEADBEEF, 32'h0, 1, "sw_1002"});
      vecs.push_back('{0, MEM_SIZE_W, 0, 32'h0, 32'h0, init_word(0), 0, "lw_0_intact"});
      vecs.push_back('{0, MEM_SIZE_W, 0, 32'h1000, 32'h0, 32'h0, 1, "lw_range"});
      vecs.push_back('{0, MEM_SIZE_ILL, 0, 32'h20, 32'h0, 32'h0, 1, "size_ill"});
      vecs.push_back('{0, MEM_SIZE_W, 1, 32'h11, 32'h0, 32'h0, 1, "lw_mis"});
      foreach (vecs[i]) begin
         got.delete();
         issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, TW'(i));
         wait_resp(1);
         if (got.size() > 0) begin
            chk({vecs[i].name, "_rdata"}, got[0].rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, "_fault"}, 32'(got[0].fault), 32'(vecs[i].exp_fault));
            chk({vecs[i].name, "_tag"}, 32'(got[0].tag), 32'(i));
         end
      end

      // Store then load the same word on consecutive accepts.
      got.delete();
      issue(1, MEM_SIZE_W, 0, 32'h20, 32'hCAFEF00D, 6'd5);
      issue(0, MEM_SIZE_W, 0, 32'h20, 32'h0, 6'd6);
      wait_resp(2);
      if (got.size() >= 2) begin
         chk("sw_lw_fwd_rdata", got[1].rdata, 32'hCAFEF00D);
         chk("sw_lw_fwd_tag", 32'(got[1].tag), 32'd6);
      end

      // Four back-to-back loads with a three-cycle consumer stall.
      got.delete();
      saw_ready_low = 0;
      nt = 1;
      for (int c = 0; c < 40 && got.size() < 4; c++) begin
         bus.resp_ready = !(c >= 3 && c < 6);
         bus.req_valid = (nt <= 4);
         bus.req_we = 0; bus.req_size = MEM_SIZE_W; bus.req_unsigned = 0;
         bus.req_addr = 32'h10; bus.req_tag = TW'(nt);
         step();
         if (last_acc) nt++;
      end
      bus.req_valid = 0;
      bus.resp_ready = 1;
      repeat (4) step();
      chk("stall_count", 32'(got.size()), 32'd4);
      chk("stall_ready_low", 32'(saw_ready_low), 32'd1);
      for (int k = 0; k < got.size() && k < 4; k++) chk("stall_tag_order", 32'(got[k].tag), 32'(k+1));

      // Reset with loads in flight.
      issue(1, MEM_SIZE_W, 0, 32'h40, 32'h11223344, 6'd9);
      issue(0, MEM_SIZE_W, 0, 32'h40, 32'h0, 6'd7);
      issue(0, MEM_SIZE_W, 0, 32'h44, 32'h0, 6'd8);
      rst = 1'b1;
      step();
      chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      rst = 1'b0;
      got.delete();
      repeat (6) step();
      chk("midrst_no_stale", 32'(got.size()), 32'd0);
      issue(0, MEM_SIZE_W, 0, 32'h40, 32'h0, 6'd10);
      wait_resp(1);
      if (got.size() > 0) chk("midrst_mem_restored", got[0].rdata, init_word(32'h40));

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         int r;
         r = $urandom_range(0, 9);
         bus.req_valid = $urandom_range(0, 2) != 0;
         bus.req_we = $urandom_range(0, 1) == 1;
         bus.req_size = ($urandom_range(0, 15) == 0) ? MEM_SIZE_ILL : 2'($urandom_range(0, 2));
         bus.req_unsigned = $urandom_range(0, 1) == 1;
         bus.req_wdata = $urandom;
         bus.req_tag = TW'($urandom);
         if (r == 0) bus.req_addr = $urandom;
         else if (r < 8) bus.req_addr = 32'($urandom_range(0, 63)) & ~((32'd1 << bus.req_size) - 1);
         else bus.req_addr = 32'($urandom_range(0, 63));
         bus.resp_ready = $urandom_range(0, 3) != 0;
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      bus.req_valid = 0;
      bus.resp_ready = 1;
      repeat (10) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_sized.md
DATA_MEM_SIZED -- requirements
Module: data_mem_sized

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, load/store data width in bits (fixed 32 in this generation).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter MEM_BYTES, default 4096, storage size in bytes (power of two, at least 4).
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from request acceptance to response (1..4).
REQ-005 SHALL have parameter TAG_WIDTH, default 6, LSQ/ROB tag width carried through.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 init_data  input  MEM_BYTES*8  initial image; byte i at bits [i*8 +: 8].
REQ-009 req_valid  input  1  request present.
REQ-010 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-011 req_we  input  1  1 = store, 0 = load.
REQ-012 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-013 req_unsigned  input  1  zero-extend load (LBU/LHU) when 1.
REQ-014 req_addr  input  ADDR_WIDTH  byte address.
REQ-015 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-016 req_tag  input  TAG_WIDTH  request tag.
REQ-017 resp_valid  output  1  response present.
REQ-018 resp_ready  input  1  consumer accepts response.
REQ-019 resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and faults.
REQ-020 resp_tag  output  TAG_WIDTH  tag of the responding request.
REQ-021 resp_fault  output  1  misaligned, out-of-range or illegal-size access.

Function
REQ-022 Accept = req_valid && req_ready; req_ready = !(resp_valid && !resp_ready) and low during rst.
REQ-023 Response pipeline: READ_LATENCY stages, each holding valid, we, size, unsigned, byte offset, fault, tag, data; whole pipeline advances when req_ready is high, freezes otherwise.
REQ-024 Every accepted request (load or store) produces exactly one response, in order, READ_LATENCY cycles after acceptance absent stalls.
REQ-025 Fault when: size 11; half with addr[0]=1; word with addr[1:0]!=0; any addr bit at or above log2(MEM_BYTES) set.
REQ-026 Store, no fault: bytes written on the accept edge, little-endian; byte writes 1 byte, half 2 bytes, word 4 bytes; other bytes unchanged.
REQ-027 Faulting store SHALL NOT modify memory.
REQ-028 Load: bytes read on the accept edge into stage 1; load accepted the cycle after a store to the same bytes returns the stored value.
REQ-029 Load extension: byte/half sign-extended unless req_unsigned=1, then zero-extended; word unaffected by req_unsigned.
REQ-030 While stalled, resp_valid/resp_rdata/resp_tag/resp_fault held stable until resp_ready.
REQ-031 Bubbles (no accept while advancing) propagate as valid=0 stages.

Reset
REQ-032 While rst high: every memory byte i loaded from init_data byte i each cycle; all pipeline valids cleared.
REQ-033 Reset values: resp_valid 0, resp_rdata 0, resp_tag 0, resp_fault 0, req_ready 0.
REQ-034 Reset mid-operation discards all in-flight responses; writes accepted before the reset edge are overwritten by init_data.

Structure
REQ-035 Size encodings (MEM_SIZE_B/H/W) and a mem_size_t typedef SHALL live in parameter_pkg.
REQ-036 One sub-module, load_extend (combinational size/offset select and sign/zero extension), SHALL be instantiated at the output stage.

Verification
REQ-037 init byte 0x10..0x13 = 78 56 34 12; load word 0x10 -> resp_rdata 0x12345678, fault 0, after READ_LATENCY cycles.
REQ-038 Store byte 0x80 to addr 0x11, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; word 0x10 -> 0x12348078.
REQ-039 Load half 0x13 -> fault 1, rdata 0; store word 0x1002 data 0xDEADBEEF (MEM_BYTES 4096) -> fault 1, no byte changes.
REQ-040 Back-to-back 4 loads tags 1..4, resp_ready low 3 cycles mid-stream -> req_ready low while stalled, tags 1..4 in order, none lost or duplicated.
REQ-041 Store word 0x20 = 0xCAFEF00D accepted, next cycle load word 0x20 -> 0xCAFEF00D.
REQ-042 Assert rst with 2 loads in flight -> resp_valid 0 next cycle, memory equals init_data, no stale response after release.
